// File: rtl/writeback_stage.sv
// ============================================================================
// Module      : writeback_stage
// Description : Final pipeline stage; waits for load data, extends it and
//               drives the registered register-file write port and retire count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_reg_write,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_result_src,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_pc_plus4,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            we3,
    output logic [4:0]      wa3,
    output logic [XLEN-1:0] wd3,
    output logic            retire,
    output logic [63:0]     instret
);

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_WAIT_LOAD = 1'b1
    } state_t;

    localparam logic [1:0] c_SRC_LOAD = 2'b01;
    localparam logic [1:0] c_SRC_PC4  = 2'b10;

    state_t            state_q;
    logic              ld_reg_write_q;
    logic [4:0]        ld_rd_q;
    logic [2:0]        ld_funct3_q;
    logic [1:0]        ld_off_q;
    logic              we3_q;
    logic [4:0]        wa3_q;
    logic [XLEN-1:0]   wd3_q;
    logic              retire_q;
    logic [63:0]       instret_q;

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_data;
    logic              nl_we;
    logic              ld_we;

    // Byte/halfword lane selection from the captured address offset
    always_comb begin
        case (ld_off_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = ld_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (ld_funct3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    assign nl_we = in_reg_write && (in_rd != 5'd0);
    assign ld_we = ld_reg_write_q && (ld_rd_q != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            ld_reg_write_q <= 1'b0;
            ld_rd_q        <= 5'd0;
            ld_funct3_q    <= 3'd0;
            ld_off_q       <= 2'd0;
            we3_q          <= 1'b0;
            wa3_q          <= 5'd0;
            wd3_q          <= '0;
            retire_q       <= 1'b0;
            instret_q      <= 64'd0;
        end else begin
            we3_q    <= 1'b0;
            retire_q <= 1'b0;
            if (retire_q) begin
                instret_q <= instret_q + 64'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (in_result_src == c_SRC_LOAD) begin
                            ld_reg_write_q <= in_reg_write;
                            ld_rd_q        <= in_rd;
                            ld_funct3_q    <= in_funct3;
                            ld_off_q       <= in_alu_result[1:0];
                            state_q        <= S_WAIT_LOAD;
                        end else begin
                            retire_q <= 1'b1;
                            we3_q    <= nl_we;
                            // wa3/wd3 only move when a write actually happens
                            if (nl_we) begin
                                wa3_q <= in_rd;
                                wd3_q <= (in_result_src == c_SRC_PC4) ? in_pc_plus4
                                                                      : in_alu_result;
                            end
                        end
                    end
                end
                S_WAIT_LOAD: begin
                    if (dmem_rvalid) begin
                        retire_q <= 1'b1;
                        we3_q    <= ld_we;
                        if (ld_we) begin
                            wa3_q <= ld_rd_q;
                            wd3_q <= ld_data;
                        end
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign we3      = we3_q;
    assign wa3      = wa3_q;
    assign wd3      = wd3_q;
    assign retire   = retire_q;
    assign instret  = instret_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ============================================================================
// Module      : tb_writeback_stage
// Description : Self-checking bench for writeback_stage with a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_result_src;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        retire;
    logic [63:0] instret;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_wait;
    bit          m_rw;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [31:0] m_addr;
    bit          e_we;
    bit          e_ret;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [63:0] e_cnt;

    writeback_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg_write  (in_reg_write),
        .in_rd         (in_rd),
        .in_result_src (in_result_src),
        .in_funct3     (in_funct3),
        .in_alu_result (in_alu_result),
        .in_pc_plus4   (in_pc_plus4),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .we3           (we3),
        .wa3           (wa3),
        .wd3           (wd3),
        .retire        (retire),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] data);
        logic [31:0] b;
        logic [31:0] h;
        b = (data >> (8 * int'(addr[1:0]))) & 32'hFF;
        h = (data >> (16 * int'(addr[1]))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            default: return data;
        endcase
    endfunction

    // One clock: predict the outcome of this edge, clock, then compare
    task automatic tick();
        chk("in_ready", in_ready, !m_wait);
        if (reset) begin
            m_wait = 0; e_we = 0; e_ret = 0; e_wa = 0; e_wd = 0; e_cnt = 0;
        end else begin
            if (e_ret) e_cnt = e_cnt + 1;
            e_we = 0; e_ret = 0;
            if (!m_wait) begin
                if (in_valid) begin
                    if (in_result_src == 2'b01) begin
                        m_wait = 1; m_rw = in_reg_write; m_rd = in_rd;
                        m_f3 = in_funct3; m_addr = in_alu_result;
                    end else begin
                        e_ret = 1;
                        if (in_reg_write && in_rd != 0) begin
                            e_we = 1; e_wa = in_rd;
                            e_wd = (in_result_src == 2'b10) ? in_pc_plus4 : in_alu_result;
                        end
                    end
                end
            end else if (dmem_rvalid) begin
                m_wait = 0; e_ret = 1;
                if (m_rw && m_rd != 0) begin
                    e_we = 1; e_wa = m_rd; e_wd = extract(m_f3, m_addr, dmem_rdata);
                end
            end
        end
        @(posedge clk);
        #1;
        chk("we3", we3, e_we);
        chk("retire", retire, e_ret);
        chk("instret", instret, e_cnt);
        if (e_we) begin
            chk("wa3", wa3, e_wa);
            chk("wd3", wd3, e_wd);
        end
    endtask

    task automatic idle_in();
        in_valid = 0; in_reg_write = 0; in_rd = 0; in_result_src = 0; in_funct3 = 0;
        in_alu_result = 0; in_pc_plus4 = 0; dmem_rvalid = 0;
    endtask

    task automatic op(input logic [4:0] rd, input logic [1:0] src, input logic [2:0] f3,
                      input logic [31:0] alu, input logic [31:0] pc4);
        in_valid = 1; in_reg_write = 1; in_rd = rd; in_result_src = src;
        in_funct3 = f3; in_alu_result = alu; in_pc_plus4 = pc4;
        tick();
        idle_in();
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input int delay);
        op(rd, 2'b01, f3, addr, 32'h0);
        dmem_rdata = rdata;
        repeat (delay - 1) tick();
        dmem_rvalid = 1;
        tick();
        dmem_rvalid = 0;
    endtask

    initial begin
        idle_in();
        dmem_rdata = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        m_wait = 0; e_we = 0; e_ret = 0; e_wa = 0; e_wd = 0; e_cnt = 0;
        chk("rst_we3", we3, 0);
        chk("rst_instret", instret, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 0;

        // Back-to-back ALU ops
        in_valid = 1; in_reg_write = 1; in_result_src = 2'b00;
        in_rd = 5; in_alu_result = 32'h1234; tick();
        chk("alu0_wd3", wd3, 32'h1234);
        in_rd = 6; in_alu_result = 32'hFFFF_0000; tick();
        chk("alu1_wd3", wd3, 32'hFFFF_0000);
        in_rd = 0; in_alu_result = 32'hDEAD; tick();
        chk("alu2_we3", we3, 0);
        chk("alu2_retire", retire, 1);
        idle_in();
        tick(); tick();
        chk("alu_instret", instret, 3);

        do_load(5'd7, 3'b000, 32'h103, 32'h80FF_0000, 4);
        chk("lb_wd3", wd3, 32'hFFFF_FF80);
        chk("lb_wa3", wa3, 7);
        chk("lb_ready", in_ready, 1);
        do_load(5'd8, 3'b101, 32'h102, 32'hBEEF_1234, 2);
        chk("lhu_wd3", wd3, 32'h0000_BEEF);
        do_load(5'd9, 3'b001, 32'h100, 32'hBEEF_1234, 1);
        chk("lh_wd3", wd3, 32'h0000_1234);
        do_load(5'd10, 3'b010, 32'h101, 32'hBEEF_1234, 3);
        chk("lw_wd3", wd3, 32'hBEEF_1234);
        do_load(5'd0, 3'b010, 32'h0, 32'h5555_5555, 2);
        chk("ldx0_we3", we3, 0);
        chk("ldx0_retire", retire, 1);
        op(5'd1, 2'b10, 3'b000, 32'hCAFE_0000, 32'h0000_0404);
        chk("jal_wd3", wd3, 32'h404);
        chk("jal_wa3", wa3, 1);

        // Reset mid-load, followed by a stale response
        op(5'd11, 2'b01, 3'b000, 32'h200, 32'h0);
        tick();
        reset = 1; tick(); reset = 0;
        dmem_rvalid = 1; tick(); dmem_rvalid = 0;
        tick();
        chk("rstld_we3", we3, 0);
        chk("rstld_retire", retire, 0);
        chk("rstld_wd3", wd3, 0);
        chk("rstld_wa3", wa3, 0);
        chk("rstld_instret", instret, 0);
        chk("rstld_ready", in_ready, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 249) == 0);
            in_valid      = $urandom_range(0, 2) != 0;
            in_reg_write  = $urandom_range(0, 3) != 0;
            in_rd         = 5'($urandom_range(0, 31));
            in_result_src = 2'($urandom_range(0, 3));
            in_funct3     = 3'($urandom_range(0, 7));
            in_alu_result = $urandom;
            in_pc_plus4   = $urandom;
            dmem_rvalid   = $urandom_range(0, 2) == 0;
            dmem_rdata    = $urandom;
            tick();
        end
        reset = 0;
        idle_in();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
